// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and state types shared by the sequential ALU
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_AND   = 4'b0010,
    OP_OR    = 4'b0011,
    OP_LUI   = 4'b0100,
    OP_SLT   = 4'b0101,
    OP_SLL   = 4'b0110,
    OP_XOR   = 4'b0111,
    OP_SRL   = 4'b1000,
    OP_SRA   = 4'b1001,
    OP_SLTU  = 4'b1010,
    OP_RSVD  = 4'b1011,
    OP_MUL   = 4'b1100,
    OP_MULHU = 4'b1101,
    OP_DIVU  = 4'b1110,
    OP_REMU  = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ONE  = 2'd1,
    S_ITER = 2'd2
  } alu_state_e;

  // Multiply and divide families all live in the 11xx opcode quadrant.
  function automatic logic is_iterative(input alu_op_e op);
    return op[3:2] == 2'b11;
  endfunction

  function automatic logic is_div(input alu_op_e op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/seq_muldiv.sv
// rtl/seq_muldiv.sv - iterative shift-add multiplier and restoring divider
module seq_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             fin,
  output logic [WIDTH-1:0] res
);

  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  alu_op_e            op_q;
  logic               running;
  logic [SHW-1:0]     cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   md;

  logic               is_mul;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic               div_ok;

  // acc holds {product high, multiplier} for multiply, quotient bits in the low half for divide.
  always_comb begin
    is_mul  = (op_q == OP_MUL) || (op_q == OP_MULHU);
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? md : {WIDTH{1'b0}})};
    shifted = {rem, acc[WIDTH-1]};
    diff    = shifted - {1'b0, md};
    div_ok  = ~diff[WIDTH];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q    <= OP_MUL;
      running <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      rem     <= '0;
      md      <= '0;
      fin     <= 1'b0;
    end else begin
      fin <= 1'b0;
      if (go) begin
        op_q    <= op;
        running <= 1'b1;
        cnt     <= '0;
        acc     <= {{WIDTH{1'b0}}, a};
        rem     <= '0;
        md      <= b;
      end else if (running) begin
        if (is_mul) begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
        end else begin
          rem          <= div_ok ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
          acc[WIDTH-1:0] <= {acc[WIDTH-2:0], div_ok};
        end
        cnt <= cnt + SHW'(1);
        if (cnt == LAST) begin
          running <= 1'b0;
          fin     <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    res = '0;
    case (op_q)
      OP_MUL, OP_DIVU: res = acc[WIDTH-1:0];
      OP_MULHU:        res = acc[2*WIDTH-1:WIDTH];
      OP_REMU:         res = rem;
      default:         res = '0;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential ALU: single-cycle integer ops plus iterative mul/div
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       alucontrol,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             Z,
  output logic             C,
  output logic             V,
  output logic             N
);

  alu_state_e       state;
  alu_op_e          op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  alu_op_e          op_in;
  logic             iter_in;
  logic             go;
  logic             fin;
  logic [WIDTH-1:0] md_res;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   add_sum;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] one_res;
  logic             one_c;
  logic             one_v;

  // Divide by zero never enters the iterative path; its answer is fixed.
  always_comb begin
    op_in   = alu_op_e'(alucontrol);
    iter_in = is_iterative(op_in) && !(is_div(op_in) && (b == '0));
    go      = (state == S_IDLE) && start && iter_in;
  end

  seq_muldiv #(.WIDTH(WIDTH), .SHW(SHW)) u_muldiv (
    .clk     (clk),
    .reset_n (reset_n),
    .go      (go),
    .op      (op_in),
    .a       (a),
    .b       (b),
    .fin     (fin),
    .res     (md_res)
  );

  always_comb begin
    b_eff   = (op_q == OP_SUB) ? ~b_q : b_q;
    add_sum = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op_q == OP_SUB)};
    shamt   = b_q[SHW-1:0];
    one_res = '0;
    one_c   = 1'b0;
    one_v   = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        one_res = add_sum[WIDTH-1:0];
        one_c   = add_sum[WIDTH];
        one_v   = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (add_sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND:  one_res = a_q & b_q;
      OP_OR:   one_res = a_q | b_q;
      OP_LUI:  one_res = b_q;
      OP_SLT:  one_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SLL:  one_res = a_q << shamt;
      OP_XOR:  one_res = a_q ^ b_q;
      OP_SRL:  one_res = a_q >> shamt;
      OP_SRA:  one_res = $signed(a_q) >>> shamt;
      OP_SLTU: one_res = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
      OP_DIVU: one_res = '1;
      OP_REMU: one_res = a_q;
      default: one_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      op_q   <= OP_ADD;
      a_q    <= '0;
      b_q    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      Z      <= 1'b0;
      C      <= 1'b0;
      V      <= 1'b0;
      N      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op_in;
            state <= iter_in ? S_ITER : S_ONE;
          end
        end
        S_ONE: begin
          result <= one_res;
          Z      <= (one_res == '0);
          N      <= one_res[WIDTH-1];
          C      <= one_c;
          V      <= one_v;
          done   <= 1'b1;
          state  <= S_IDLE;
        end
        S_ITER: begin
          if (fin) begin
            result <= md_res;
            Z      <= (md_res == '0);
            N      <= md_res[WIDTH-1];
            C      <= 1'b0;
            V      <= 1'b0;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end else begin
            busy <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu (WIDTH=32)
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  alucontrol;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;
  logic        Z, C, V, N;

  int n_cmp = 0;
  int n_fail = 0;

  seq_alu #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .alucontrol (alucontrol),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .Z          (Z),
    .C          (C),
    .V          (V),
    .N          (N)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  zcvn;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic [3:0] zcvn, output int lat);
    logic [63:0] p;
    longint      s;
    logic        c, v;
    c = 1'b0; v = 1'b0; lat = 1; r = '0;
    p = {32'b0, x} * {32'b0, y};
    case (op)
      4'h0: begin
        s = longint'($signed(x)) + longint'($signed(y));
        r = x + y;
        c = ({32'b0, x} + {32'b0, y}) > 64'hFFFF_FFFF;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h1: begin
        s = longint'($signed(x)) - longint'($signed(y));
        r = x - y;
        c = (x >= y);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h2: r = x & y;
      4'h3: r = x | y;
      4'h4: r = y;
      4'h5: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'h6: r = x << y[4:0];
      4'h7: r = x ^ y;
      4'h8: r = x >> y[4:0];
      4'h9: r = 32'($signed(x) >>> y[4:0]);
      4'hA: r = (x < y) ? 32'd1 : 32'd0;
      4'hC: begin r = p[31:0];  lat = 33; end
      4'hD: begin r = p[63:32]; lat = 33; end
      4'hE: begin r = (y == 0) ? 32'hFFFF_FFFF : x / y; lat = (y == 0) ? 1 : 33; end
      4'hF: begin r = (y == 0) ? x : x % y;             lat = (y == 0) ? 1 : 33; end
      default: r = '0;
    endcase
    zcvn = {(r == 0), c, v, r[31]};
  endfunction

  task automatic do_op(input logic [3:0] op, input logic [31:0] ia, input logic [31:0] ib,
                       output logic [31:0] r, output logic [3:0] f, output int lat, output int bc);
    @(negedge clk);
    alucontrol = op; a = ia; b = ib; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = $urandom; b = $urandom; alucontrol = 4'($urandom);
    lat = 0; bc = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) bc++;
      if (done) break;
    end
    r = result;
    f = {Z, C, V, N};
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] r, er;
    logic [3:0]  f, ef;
    int          lat, elat, bc;
    logic        seen;

    vecs[0]  = '{4'h0, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 4'b0011, 1};
    vecs[1]  = '{4'h1, 32'h5,         32'h5,         32'h0,         4'b1100, 1};
    vecs[2]  = '{4'h9, 32'h8000_0000, 32'h4,         32'hF800_0000, 4'b0001, 1};
    vecs[3]  = '{4'hC, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFE, 4'b0001, 33};
    vecs[4]  = '{4'hD, 32'hFFFF_FFFF, 32'h2,         32'h1,         4'b0000, 33};
    vecs[5]  = '{4'hE, 32'd100,       32'd7,         32'd14,        4'b0000, 33};
    vecs[6]  = '{4'hF, 32'd100,       32'd7,         32'd2,         4'b0000, 33};
    vecs[7]  = '{4'hE, 32'h1234,      32'h0,         32'hFFFF_FFFF, 4'b0001, 1};
    vecs[8]  = '{4'hF, 32'd9,         32'h0,         32'd9,         4'b0000, 1};
    vecs[9]  = '{4'h5, 32'hFFFF_FFFF, 32'h1,         32'h1,         4'b0000, 1};
    vecs[10] = '{4'hA, 32'hFFFF_FFFF, 32'h1,         32'h0,         4'b1000, 1};
    vecs[11] = '{4'hB, 32'h1234,      32'h5678,      32'h0,         4'b1000, 1};
    vecs[12] = '{4'h6, 32'h1,         32'd31,        32'h8000_0000, 4'b0001, 1};
    vecs[13] = '{4'h1, 32'h0,         32'h1,         32'hFFFF_FFFF, 4'b0001, 1};
    vecs[14] = '{4'h1, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 4'b0110, 1};

    reset_n = 1'b0; start = 1'b0; alucontrol = '0; a = '0; b = '0;
    #12;
    chk("reset_outputs", {busy, done, result, Z, C, V, N}, '0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, r, f, lat, bc);
      chk($sformatf("vec%0d_result", i), r, vecs[i].res);
      chk($sformatf("vec%0d_flags", i), f, vecs[i].zcvn);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_busy_cycles", i), bc, (vecs[i].lat == 33) ? 32 : 0);
    end

    for (int i = 0; i < 60; i++) begin
      logic [3:0]  op;
      logic [31:0] x, y;
      op = 4'($urandom_range(0, 15));
      x  = $urandom;
      y  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      model(op, x, y, er, ef, elat);
      do_op(op, x, y, r, f, lat, bc);
      chk($sformatf("rnd%0d_op%0h_result", i, op), r, er);
      chk($sformatf("rnd%0d_op%0h_flags", i, op), f, ef);
      chk($sformatf("rnd%0d_op%0h_latency", i, op), lat, elat);
    end

    // start mid-divide with new operands must be ignored
    @(negedge clk);
    alucontrol = 4'hE; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 5) begin start = 1'b1; alucontrol = 4'hE; a = 32'd1000; b = 32'd3; end
      if (lat == 6) start = 1'b0;
      if (done) break;
    end
    chk("ignored_start_quotient", result, 32'd14);
    chk("ignored_start_latency", lat, 33);

    // back-to-back start in the done cycle
    start = 1'b1; alucontrol = 4'h0; a = 32'd2; b = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("done_is_pulse", done, 1'b0);
    @(posedge clk);
    #1;
    chk("b2b_done", done, 1'b1);
    chk("b2b_result", result, 32'd5);

    // reset at iteration 10 of a multiply
    @(negedge clk);
    alucontrol = 4'hC; a = 32'h1234_5678; b = 32'h9; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("busy_before_reset", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("reset_mid_mul_outputs", {busy, done, result, Z, C, V, N}, '0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1'b1;
    end
    chk("no_done_after_abort", seen, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, sequential ALU for the multi-cycle RISC-V datapath. It runs the single-cycle integer operations and also executes multiply, unsigned divide and unsigned remainder iteratively. Operands are captured on a start/done handshake. The result and the Z/C/V/N flags are registered and held stable for the controller FSM until the next completed operation.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width; must be ≥ 8 and a power of two.
- `SHW`, `$clog2(WIDTH)`, number of shift-amount bits taken from `b`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `alucontrol`  in  4  operation code (see Operation).
- `a`, `b`  in  WIDTH  operands; captured on an accepted `start`.
- `busy`  out  1  high while an iterative operation is in progress.
- `done`  out  1  one-cycle pulse: `result` and flags are valid from this cycle on.
- `result`  out  WIDTH  registered result.
- `Z`, `C`, `V`, `N`  out  1  registered flags.

## Operation
- Opcodes:
  - 0000 add; 0001 sub; 0010 and; 0011 or; 0100 pass `b` (lui).
  - 0101 slt (signed, zero-extended 0/1); 0110 sll; 0111 xor.
  - 1000 srl; 1001 sra; 1010 sltu.
  - 1100 mul, low WIDTH bits of a*b; 1101 mulhu, high WIDTH bits of unsigned a*b.
  - 1110 divu; 1111 remu; 1011 reserved → result 0.
- Shift amount is `b[SHW-1:0]`.
- add/sub use `a + (b or ~b) + sub`, computed WIDTH+1 bits wide.
  - C = carry out. For sub, C=1 means no borrow.
  - V = signed overflow.
  - C and V are 0 for all other ops.
- Z = (result==0) and N = result[WIDTH-1], for every op.
- FSM states:
  - IDLE → ONE: accepted `start` with a single-cycle op.
  - IDLE → ITER: accepted `start` with a mul/div op.
  - ONE → IDLE: always, asserting `done`.
  - ITER → IDLE: when the iteration counter reaches WIDTH-1, asserting `done`.
- Multiply: shift-add, one partial product per cycle, 2·WIDTH-bit accumulator.
- Divide: restoring, one quotient bit per cycle, WIDTH+1-bit partial remainder.
- Divide by zero: no iteration. Treated as a single-cycle op with divu = all ones and remrem = `a`.
- `start` while `busy`=1 is ignored and does not queue. Operand changes while busy have no effect.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, counter 0; `busy`, `done`, `result` and all flags are 0.
- Single-cycle ops: `start` accepted at edge k → `done`=1 and `result` valid after edge k+1. `busy` stays 0.
- Iterative ops: `start` accepted at edge k → `busy`=1 after edge k+1 through edge k+WIDTH. After edge k+WIDTH+1, `done`=1 and `busy`=0. Latency is WIDTH+1 cycles (33 for WIDTH=32).
- A `start` in the `done` cycle is accepted (back-to-back operation).
- `result` and flags change only in the cycle `done` rises; otherwise they hold.
- `reset_n` low mid-iteration aborts the operation: no `done`, outputs cleared.

## Structure
- Package `alu_pkg`:
  - `alu_op_e` (4-bit opcode enum);
  - `alu_state_e` (IDLE, ONE, ITER);
  - helper `is_iterative(op)`.
- Sub-module `seq_muldiv`: iterative multiply/divide datapath with its own counter. Handshake to `seq_alu`: `go` in, `fin` out.
- `seq_alu` holds the FSM, the combinational single-cycle ops, the flag logic and the output registers.

## Test plan
- WIDTH=32, add 0x7FFFFFFF+1 → result 0x80000000, V=1, N=1, C=0, Z=0; `done` one cycle after `start`.
- sub 5−5 → result 0, Z=1, C=1. Then sra 0x80000000 by 4 → 0xF8000000, N=1.
- mul 0xFFFFFFFF·2:
  - `busy` 32 cycles, `done` at cycle 33, result 0xFFFFFFFE;
  - same operands with mulhu → 0x00000001.
- divu 100/7 → 14; remu 100/7 → 2. divu x/0 → 0xFFFFFFFF in 1 cycle; remu 9/0 → 9.
- `start` pulsed mid-divide with new operands → ignored, original quotient delivered. `start` in the `done` cycle → accepted.
- `reset_n` low at iteration 10 of mul → `busy`, `done`, `result` and flags all 0 immediately; no `done` pulse afterwards.
